tile_controller: RTL and testbench
==================================

TILE_CONTROLLER -- requirements
Module: tile_controller

Interface
REQ-001 Parameter IF_CH, default 4, number of independent input-feature-map read lanes (>=1).
REQ-002 Parameter TILE_W, default 8, width of tile count and tile index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 start  input  1  begin a job; sampled only in IDLE.
REQ-006 num_tiles  input  TILE_W  tiles in job; latched on accepted start.
REQ-007 w_done  input  1  weight buffer fill complete; honoured only while w_read=1.
REQ-008 if_done  input  IF_CH  per-lane ifmap stream complete; honoured only while that lane's if_read=1.
REQ-009 w_read  output  1  weight fetch enable (first load or prefetch).
REQ-010 if_read  output  IF_CH  per-lane ifmap fetch enable.
REQ-011 clr_w  output  1  one-cycle pulse clearing weight address counter.
REQ-012 clr_if  output  IF_CH  one-cycle pulse per lane clearing ifmap address counter.
REQ-013 switch  output  1  one-cycle pulse swapping shadow/active weight buffers.
REQ-014 ready  output  1  high only in IDLE.
REQ-015 done  output  1  one-cycle pulse at job completion.
REQ-016 tile_idx  output  TILE_W  index of tile currently streaming.

Function
REQ-017 FSM states SHALL be IDLE, W_LOAD, SWAP, STREAM, FINISH; all outputs decoded from registered state/flags (Moore).
REQ-018 IDLE: start=1 and num_tiles!=0 -> W_LOAD next edge, latch num_tiles, tile_idx=0; num_tiles==0 -> start ignored, stay IDLE.
REQ-019 W_LOAD: w_read=1; w_done=1 -> clr_w pulse next cycle, state SWAP.
REQ-020 SWAP: exactly one cycle; switch=1 and clr_if=all ones; clear lane done mask and prefetch flag; next STREAM.
REQ-021 STREAM: if_read[i]=1 for each lane whose sticky done bit is 0; if_done[i] sets bit i, if_read[i] drops next cycle.
REQ-022 STREAM prefetch: w_read=1 while tile_idx+1<num_tiles and prefetch flag 0; w_done sets flag and pulses clr_w next cycle.
REQ-023 STREAM exit: all done bits set and (prefetch flag set or last tile); last tile -> FINISH, else tile_idx+1, SWAP.
REQ-024 FINISH: one cycle, done=1; next IDLE.
REQ-025 Simultaneous final if_done and w_done in one cycle SHALL exit STREAM on the following edge (no extra wait cycle).
REQ-026 if_done on an already-done lane, w_done outside a read window, start outside IDLE: ignored, no state effect.
REQ-027 Latency: start sampled at edge N -> w_read high from cycle N+1; w_done sampled at edge M -> switch at cycle M+1 (clr_w coincident).
REQ-028 tile_idx SHALL not wrap; max legal num_tiles is 2^TILE_W-1.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, tile_idx=0, masks/flags cleared, all pulses/enables 0, ready=1.
REQ-030 Reset mid-job SHALL abandon job; no done pulse issued.

Structure
REQ-031 Package tile_ctrl_pkg SHALL hold state enum typedef and default parameter constants.
REQ-032 Sub-module if_lane_tracker (IF_CH-wide sticky done mask, if_read generation, all_done flag) SHALL be instantiated once.

Verification
REQ-033 IF_CH=4, num_tiles=1, w_done after 5 cycles, lanes done at 3,4,7,9 cycles -> one switch, no prefetch w_read, done once, ready returns.
REQ-034 num_tiles=3, prefetch w_done before lanes finish -> 3 switch pulses, tile_idx 0,1,2, w_read during STREAM of tiles 0,1 only.
REQ-035 Prefetch w_done after all lanes done -> STREAM held until w_done, then SWAP next edge; simultaneous case exits with zero wait.
REQ-036 start with num_tiles=0, start during STREAM, duplicate if_done, stray w_done -> no effect on state/outputs.
REQ-037 rst=0 asserted mid-STREAM -> outputs cleared asynchronously, no done; fresh start after release runs normally.

Source files
------------

// File: rtl/tile_ctrl_pkg.sv
// Shared types and default sizing for the tile controller and its lane tracker.
package tile_ctrl_pkg;

  localparam int unsigned IF_CH_DEF  = 4;
  localparam int unsigned TILE_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_LOAD = 3'd1,
    SWAP   = 3'd2,
    STREAM = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/if_lane_tracker.sv
// Sticky per-lane done mask for the ifmap read lanes; drives the registered
// per-lane read enables and reports when every lane has finished.
module if_lane_tracker
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned IF_CH = IF_CH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             stream_next,
  input  logic [IF_CH-1:0] if_done,
  output logic [IF_CH-1:0] if_read,
  output logic             all_done
);

  logic [IF_CH-1:0] mask;
  logic [IF_CH-1:0] mask_d;

  // A done strobe only counts for a lane that is currently reading.
  always_comb begin
    mask_d = mask;
    if (clr) begin
      mask_d = '0;
    end else if (en) begin
      mask_d = mask | (if_done & if_read);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask    <= '0;
      if_read <= '0;
    end else begin
      mask    <= mask_d;
      if_read <= stream_next ? ~mask_d : '0;
    end
  end

  assign all_done = &mask;

endmodule

// File: rtl/tile_controller.sv
// Sequences weight loads, buffer swaps and per-lane ifmap streaming for a
// multi-tile job, prefetching the next tile's weights during streaming.
module tile_controller
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned IF_CH  = IF_CH_DEF,
  parameter int unsigned TILE_W = TILE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              w_done,
  input  logic [IF_CH-1:0]  if_done,
  output logic              w_read,
  output logic [IF_CH-1:0]  if_read,
  output logic              clr_w,
  output logic [IF_CH-1:0]  clr_if,
  output logic              switch,
  output logic              ready,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int unsigned CW = TILE_W + 1;

  state_t            state, state_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TILE_W-1:0] idx_d;
  logic              pf, pf_d;
  logic              clr_w_d;
  logic              w_read_d;
  logic              more, more_d;
  logic              all_done;

  // Widened compare so tile_idx+1 cannot wrap at the top of the range.
  assign more   = (({1'b0, tile_idx} + CW'(1)) < {1'b0, num_q});
  assign more_d = (({1'b0, idx_d} + CW'(1)) < {1'b0, num_d});

  always_comb begin
    state_d = state;
    num_d   = num_q;
    idx_d   = tile_idx;
    pf_d    = pf;
    clr_w_d = 1'b0;
    case (state)
      IDLE: begin
        if (start && (num_tiles != '0)) begin
          state_d = W_LOAD;
          num_d   = num_tiles;
          idx_d   = '0;
        end
      end
      W_LOAD: begin
        if (w_done && w_read) begin
          state_d = SWAP;
          clr_w_d = 1'b1;
        end
      end
      SWAP: begin
        pf_d    = 1'b0;
        state_d = STREAM;
      end
      STREAM: begin
        if (w_done && w_read) begin
          pf_d    = 1'b1;
          clr_w_d = 1'b1;
        end
        if (all_done && (pf || !more)) begin
          if (!more) begin
            state_d = FINISH;
          end else begin
            idx_d   = tile_idx + TILE_W'(1);
            state_d = SWAP;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    w_read_d = (state_d == W_LOAD) ||
               ((state_d == STREAM) && more_d && !pf_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      num_q    <= '0;
      tile_idx <= '0;
      pf       <= 1'b0;
      w_read   <= 1'b0;
      clr_w    <= 1'b0;
      clr_if   <= '0;
      switch   <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      num_q    <= num_d;
      tile_idx <= idx_d;
      pf       <= pf_d;
      w_read   <= w_read_d;
      clr_w    <= clr_w_d;
      clr_if   <= {IF_CH{state_d == SWAP}};
      switch   <= (state_d == SWAP);
      ready    <= (state_d == IDLE);
      done     <= (state_d == FINISH);
    end
  end

  if_lane_tracker #(
    .IF_CH (IF_CH)
  ) u_lanes (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == SWAP),
    .en          (state == STREAM),
    .stream_next (state_d == STREAM),
    .if_done     (if_done),
    .if_read     (if_read),
    .all_done    (all_done)
  );

endmodule

// File: tb/tb_tile_controller.sv
// Directed bench for tile_controller: cycle table for a one-tile job with
// ignored stimuli, plus hand sequences for prefetch, overlap and reset.
module tb_tile_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_tiles;
  logic       w_done;
  logic [3:0] if_done;
  logic       w_read;
  logic [3:0] if_read;
  logic       clr_w;
  logic [3:0] clr_if;
  logic       switch;
  logic       ready;
  logic       done;
  logic [7:0] tile_idx;

  int n_chk;
  int n_fail;
  int done_cnt;

  tile_controller #(
    .IF_CH  (4),
    .TILE_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_tiles (num_tiles),
    .w_done    (w_done),
    .if_done   (if_done),
    .w_read    (w_read),
    .if_read   (if_read),
    .clr_w     (clr_w),
    .clr_if    (clr_if),
    .switch    (switch),
    .ready     (ready),
    .done      (done),
    .tile_idx  (tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic        st;
    logic [7:0]  n;
    logic        wd;
    logic [3:0]  ifd;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [20:0] o(input logic wr, input logic [3:0] ifr,
                                    input logic cw, input logic [3:0] cif,
                                    input logic sw, input logic rdy,
                                    input logic dn, input logic [7:0] idx);
    return {wr, ifr, cw, cif, sw, rdy, dn, idx};
  endfunction

  function automatic logic [20:0] act();
    return {w_read, if_read, clr_w, clr_if, switch, ready, done, tile_idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [7:0] n, input logic wd, input logic [3:0] ifd);
    start     = st;
    num_tiles = n;
    w_done    = wd;
    if_done   = ifd;
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_tiles = 8'd0;
    w_done    = 1'b0;
    if_done   = 4'd0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0;
    rst = 1'b0; start = 1'b0; num_tiles = 8'd0; w_done = 1'b0; if_done = 4'd0;

    // One-tile job: w_done 5 cycles after start, lanes at stream cycles 3,4,7,9,
    // with stray/duplicate/start stimuli mid-stream that must have no effect.
    tbl[0]  = '{1'b1, 8'd0, 1'b0, 4'h0, o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 4'h0, o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)};
    tbl[2]  = '{1'b1, 8'd1, 1'b0, 4'h0, o(1, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(1, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(1, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(1, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(1, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[7]  = '{1'b0, 8'd0, 1'b1, 4'h0, o(0, 4'h0, 1, 4'hF, 1, 0, 0, 8'd0)};
    tbl[8]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'hF, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'hF, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[10] = '{1'b0, 8'd0, 1'b0, 4'h1, o(0, 4'hE, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[11] = '{1'b0, 8'd0, 1'b0, 4'h2, o(0, 4'hC, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[12] = '{1'b1, 8'd5, 1'b1, 4'h1, o(0, 4'hC, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[13] = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'hC, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[14] = '{1'b0, 8'd0, 1'b0, 4'h4, o(0, 4'h8, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'h8, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[16] = '{1'b0, 8'd0, 1'b0, 4'h8, o(0, 4'h0, 0, 4'h0, 0, 0, 0, 8'd0)};
    tbl[17] = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'h0, 0, 4'h0, 0, 0, 1, 8'd0)};
    tbl[18] = '{1'b0, 8'd0, 1'b0, 4'h0, o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(act()), 32'(o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)));
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].st, tbl[i].n, tbl[i].wd, tbl[i].ifd);
      chk($sformatf("vec%0d", i), 32'(act()), 32'(tbl[i].exp));
    end

    // Three tiles: early prefetch on tile 0, late prefetch on tile 1.
    cyc(1'b1, 8'd3, 1'b0, 4'h0); chk("a_wload", {w_read, tile_idx}, {1'b1, 8'd0});
    cyc(1'b0, 8'd0, 1'b1, 4'h0); chk("a_swap0", {switch, clr_w, clr_if}, 6'b111111);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_pf_rd0", {w_read, if_read}, 5'b11111);
    cyc(1'b0, 8'd0, 1'b1, 4'h0); chk("a_pf_ack0", {w_read, clr_w, switch}, 3'b010);
    cyc(1'b0, 8'd0, 1'b0, 4'hF); chk("a_lanes0", {if_read, switch}, 5'b00000);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_swap1", {switch, tile_idx}, {1'b1, 8'd1});
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_pf_rd1", {w_read, if_read}, 5'b11111);
    cyc(1'b0, 8'd0, 1'b0, 4'hF); chk("a_lanes1", {w_read, if_read}, 5'b10000);
    repeat (2) begin
      cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_hold", {w_read, switch, clr_w}, 3'b100);
    end
    cyc(1'b0, 8'd0, 1'b1, 4'h0); chk("a_pf_ack1", {w_read, clr_w, switch}, 3'b010);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_swap2", {switch, tile_idx}, {1'b1, 8'd2});
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_last_rd", {w_read, if_read}, 5'b01111);
    cyc(1'b0, 8'd0, 1'b0, 4'hF); chk("a_last_lanes", {w_read, if_read, done}, 6'b000000);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_finish", {done, tile_idx}, {1'b1, 8'd2});
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("a_idle", {ready, done}, 2'b10);

    // Two tiles: final lanes and prefetch w_done land in the same cycle.
    cyc(1'b1, 8'd2, 1'b0, 4'h0);
    cyc(1'b0, 8'd0, 1'b1, 4'h0); chk("s_swap0", switch, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("s_rd0", {w_read, if_read}, 5'b11111);
    cyc(1'b0, 8'd0, 1'b1, 4'hF); chk("s_both", {w_read, if_read, clr_w, switch}, 7'b0000010);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("s_swap1", {switch, tile_idx}, {1'b1, 8'd1});
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("s_rd1", {w_read, if_read}, 5'b01111);
    cyc(1'b0, 8'd0, 1'b0, 4'hF);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("s_finish", done, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("s_idle", ready, 1'b1);

    // Reset mid-stream abandons the job; a fresh job then runs normally.
    cyc(1'b1, 8'd2, 1'b0, 4'h0);
    cyc(1'b0, 8'd0, 1'b1, 4'h0);
    cyc(1'b0, 8'd0, 1'b0, 4'h1); chk("r_stream", {w_read, if_read}, 5'b11111);
    #2 rst = 1'b0;
    #1 chk("r_async", 32'(act()), 32'(o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)));
    repeat (3) cyc(1'b0, 8'd0, 1'b0, 4'h0);
    chk("r_held", 32'(act()), 32'(o(0, 4'h0, 0, 4'h0, 0, 1, 0, 8'd0)));
    rst = 1'b1;
    cyc(1'b1, 8'd1, 1'b0, 4'h0); chk("r_wload", {w_read, ready, tile_idx}, {2'b10, 8'd0});
    cyc(1'b0, 8'd0, 1'b1, 4'h0); chk("r_swap", {switch, clr_w}, 2'b11);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("r_rd", {w_read, if_read}, 5'b01111);
    cyc(1'b0, 8'd0, 1'b0, 4'hF);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("r_finish", done, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 4'h0); chk("r_idle", {ready, done}, 2'b10);

    chk("done_count", 32'(done_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
